countdown_display_driver: RTL and testbench

Consumer end of the round countdown timer: samples the 5-bit remaining-seconds value (0–31) produced by the game timer and drives a 4-digit, time-multiplexed, active-low seven-segment display with it. Shows seconds as two decimal digits with leading-zero blanking, blinks the display during the final seconds, and emits a one-cycle `time_up` pulse when the count reaches zero. Sits between the timer and the board display pins, clocked by the 100 MHz system clock.

---
 rtl/countdown_display_driver.sv | 139 +++++++++++++
 tb/tb_countdown_display_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/countdown_display_driver.sv
// Drives a 4-digit multiplexed active-low seven-segment display from the
// 5-bit remaining-seconds value, with warning blink and a time-up pulse.
module countdown_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned WARN_LEVEL  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] time_display,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       warn,
  output logic       time_up
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4:0]    s_q, p_q;
  logic [1:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [RW-1:0] ref_cnt, ref_d;
  logic [1:0]    sel, sel_d;
  logic [BW-1:0] blink_cnt, blink_d;
  logic          phase, phase_d;
  logic          tick;
  logic          warn_d, time_up_d;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q       <= '0;
      p_q       <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      ref_cnt   <= '0;
      sel       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      warn      <= 1'b0;
      time_up   <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      s_q       <= time_display;
      p_q       <= s_q;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ref_cnt   <= ref_d;
      sel       <= sel_d;
      blink_cnt <= blink_d;
      phase     <= phase_d;
      warn      <= warn_d;
      time_up   <= time_up_d;
      an        <= an_d;
      seg       <= seg_d;
      dp        <= 1'b1;
    end
  end

  always_comb begin
    tens_d    = 2'd0;
    ones_d    = 4'(s_q);
    tick      = (ref_cnt == RW'(REFRESH_DIV - 1));
    ref_d     = tick ? '0 : ref_cnt + RW'(1);
    sel_d     = tick ? sel + 2'd1 : sel;
    blink_d   = '0;
    phase_d   = 1'b1;
    warn_d    = enable && (s_q != 5'd0) && (32'(s_q) <= WARN_LEVEL);
    time_up_d = enable && (p_q != 5'd0) && (s_q == 5'd0);
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;

    if (s_q >= 5'd30) begin
      tens_d = 2'd3;
      ones_d = 4'(s_q - 5'd30);
    end else if (s_q >= 5'd20) begin
      tens_d = 2'd2;
      ones_d = 4'(s_q - 5'd20);
    end else if (s_q >= 5'd10) begin
      tens_d = 2'd1;
      ones_d = 4'(s_q - 5'd10);
    end

    // Blink timer only advances inside the warning window.
    if (warn) begin
      phase_d = phase;
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase;
      end else begin
        blink_d = blink_cnt + BW'(1);
      end
    end

    // Decode against the upcoming slot so anode and segments switch together.
    if (enable && phase) begin
      case (sel_d)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = seg7(ones_q);
        end
        2'd1: begin
          if (tens_q != 2'd0) begin
            an_d  = 4'b1101;
            seg_d = seg7({2'b00, tens_q});
          end
        end
        default: begin
          an_d  = 4'b1111;
          seg_d = 7'b1111111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_display_driver.sv
// Randomized scoreboard bench for countdown_display_driver with an
// arithmetic reference model of the display, blink and time-up behaviour.
module tb_countdown_display_driver;

  localparam int unsigned R = 4;
  localparam int unsigned B = 8;
  localparam int unsigned W = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [4:0] time_display = 5'd23;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       warn;
  logic       time_up;

  countdown_display_driver #(
    .REFRESH_DIV(R),
    .BLINK_DIV  (B),
    .WARN_LEVEL (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .time_display(time_display),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .warn        (warn),
    .time_up     (time_up)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       warn;
    logic       tu;
    logic       rst;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] ENC [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Model state: edges since reset, last two sampled values, warn run length.
  int   n = 0;
  int   x1 = 0;
  int   x2 = 0;
  logic w_prev = 1'b0;
  int   r_prev = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and push the predicted outputs for that edge.
  task automatic step(input logic rst_in, input logic en, input logic [4:0] v);
    exp_t e;
    int   s;
    logic ph;
    int   tens, ones, r_n;
    @(negedge clk);
    reset        = rst_in;
    enable       = en;
    time_display = v;
    e.an   = 4'b1111;
    e.seg  = 7'b1111111;
    e.warn = 1'b0;
    e.tu   = 1'b0;
    e.rst  = rst_in;
    if (rst_in) begin
      n = 0; x1 = 0; x2 = 0; w_prev = 1'b0; r_prev = 0;
    end else begin
      n++;
      s    = (n / R) % 4;
      ph   = ((r_prev / B) % 2) == 0;
      tens = x2 / 10;
      ones = x2 % 10;
      if (en && ph) begin
        if (s == 0) begin
          e.an  = 4'b1110;
          e.seg = ENC[ones];
        end else if (s == 1 && tens != 0) begin
          e.an  = 4'b1101;
          e.seg = ENC[tens];
        end
      end
      e.warn = en && x1 >= 1 && x1 <= W;
      e.tu   = en && x2 != 0 && x1 == 0;
      r_n    = w_prev ? r_prev + 1 : 0;
      x2     = x1;
      x1     = int'(v);
      w_prev = e.warn;
      r_prev = r_n;
    end
    q.push_back(e);
  endtask

  task automatic hold(input logic en, input logic [4:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, en, v);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", int'(an), int'(e.an));
      chk("warn", int'(warn), int'(e.warn));
      chk("time_up", int'(time_up), int'(e.tu));
      chk("dp", int'(dp), 1);
      if (e.an != 4'b1111 || e.rst) chk("seg", int'(seg), int'(e.seg));
    end
  end

  initial begin
    int len;
    logic [4:0] v;
    logic en;
    // Reset held with live inputs.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd23);
    hold(1'b1, 5'd23, 24);
    hold(1'b1, 5'd7, 20);
    hold(1'b1, 5'd5, 40);
    hold(1'b1, 5'd6, 12);
    hold(1'b1, 5'd2, 4);
    hold(1'b1, 5'd1, 4);
    hold(1'b1, 5'd0, 10);
    hold(1'b1, 5'd30, 20);
    hold(1'b0, 5'd2, 4);
    hold(1'b0, 5'd1, 4);
    hold(1'b0, 5'd0, 10);
    // Reset landing mid-blink and mid-scan.
    hold(1'b1, 5'd4, 30);
    for (int i = 0; i < 16; i++) begin
      if ((n / R) % 4 == 2) break;
      step(1'b0, 1'b1, 5'd4);
    end
    step(1'b1, 1'b1, 5'd4);
    hold(1'b1, 5'd3, 12);
    // Random segments of held values, biased toward the warning range.
    for (int k = 0; k < 150; k++) begin
      len = int'($urandom_range(1, 30));
      v   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                         : 5'($urandom_range(0, 7));
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) step(1'b1, en, v);
      hold(en, v, len);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
